// File: rtl/loop_accumulator_pkg.sv
// Shared encodings for the loop accumulator: update modes and FSM states.
package loop_accumulator_pkg;

    localparam logic [1:0] MODE_ADD_CONST = 2'b00;
    localparam logic [1:0] MODE_SUB_CONST = 2'b01;
    localparam logic [1:0] MODE_ADD_INDEX = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/loop_accumulator_if.sv
// Start/done handshake and result bus between a requester and the loop accumulator.
interface loop_accumulator_if
    import loop_accumulator_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) ();

    logic                 start;
    logic [1:0]           mode;
    logic [CNT_WIDTH-1:0] count;
    logic [WIDTH-1:0]     init;
    logic [WIDTH-1:0]     step;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     out;
    logic [CNT_WIDTH-1:0] iter;
    logic                 ovf;

    modport master (
        output start, mode, count, init, step,
        input  busy, done, out, iter, ovf
    );

    modport slave (
        input  start, mode, count, init, step,
        output busy, done, out, iter, ovf
    );

endinterface

// File: rtl/loop_acc_alu.sv
// Combinational update for one iteration; carry reports unsigned carry-out or borrow.
module loop_acc_alu
    import loop_accumulator_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic [WIDTH-1:0]     acc,
    input  logic [WIDTH-1:0]     step,
    input  logic [CNT_WIDTH-1:0] index,
    input  logic [1:0]           mode,
    output logic [WIDTH-1:0]     next_acc,
    output logic                 carry
);

    logic [WIDTH-1:0] index_ext_s;
    logic [WIDTH:0]   sum_s;

    assign index_ext_s = WIDTH'(index);

    // One extra bit captures the carry-out; for subtraction it goes high on borrow.
    always_comb begin
        sum_s = {(WIDTH+1){1'b0}};
        case (mode)
            MODE_SUB_CONST: sum_s = {1'b0, acc} - {1'b0, step};
            MODE_ADD_INDEX: sum_s = {1'b0, acc} + {1'b0, index_ext_s};
            default:        sum_s = {1'b0, acc} + {1'b0, step};
        endcase
    end

    assign next_acc = sum_s[WIDTH-1:0];
    assign carry    = sum_s[WIDTH];

endmodule

// File: rtl/loop_accumulator.sv
// Start/done iteration engine: IDLE/RUN/DONE FSM with latched operands and sticky overflow.
module loop_accumulator
    import loop_accumulator_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    loop_accumulator_if.slave bus
);

    state_t               state_r;
    logic [1:0]           mode_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic [WIDTH-1:0]     step_r;
    logic [WIDTH-1:0]     out_r;
    logic [CNT_WIDTH-1:0] iter_r;
    logic                 ovf_r;
    logic                 busy_r;
    logic                 done_r;
    logic [WIDTH-1:0]     next_acc_s;
    logic                 carry_s;

    loop_acc_alu #(
        .WIDTH     (WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_alu (
        .acc      (out_r),
        .step     (step_r),
        .index    (iter_r),
        .mode     (mode_r),
        .next_acc (next_acc_s),
        .carry    (carry_s)
    );

    // FSM, operand latches, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
            mode_r  <= MODE_ADD_CONST;
            count_r <= {CNT_WIDTH{1'b0}};
            step_r  <= {WIDTH{1'b0}};
            out_r   <= {WIDTH{1'b0}};
            iter_r  <= {CNT_WIDTH{1'b0}};
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_r  <= bus.mode;
                        count_r <= bus.count;
                        step_r  <= bus.step;
                        out_r   <= bus.init;
                        iter_r  <= {CNT_WIDTH{1'b0}};
                        ovf_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        if (bus.count != {CNT_WIDTH{1'b0}}) begin
                            state_r <= S_RUN;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                S_RUN: begin
                    out_r  <= next_acc_s;
                    iter_r <= iter_r + CNT_WIDTH'(1);
                    ovf_r  <= ovf_r | carry_s;
                    busy_r <= 1'b1;
                    // Final iteration: the result registered on this edge is the answer.
                    if (iter_r == count_r - CNT_WIDTH'(1)) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.out  = out_r;
    assign bus.iter = iter_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_loop_accumulator.sv
// Directed bench for loop_accumulator: a 32-bit and an 8-bit instance, hand-computed expectations.
module tb_loop_accumulator;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   edges;

    loop_accumulator_if #(.WIDTH(32), .CNT_WIDTH(8)) b32 ();
    loop_accumulator_if #(.WIDTH(8),  .CNT_WIDTH(8)) b8  ();

    loop_accumulator #(.WIDTH(32), .CNT_WIDTH(8)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (b32)
    );

    loop_accumulator #(.WIDTH(8), .CNT_WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one start on the 32-bit instance at edge E0, then scramble the inputs.
    task automatic start32(input logic [1:0] m, input logic [7:0] c,
                           input logic [31:0] i, input logic [31:0] s);
        @(negedge clk);
        b32.mode  = m;
        b32.count = c;
        b32.init  = i;
        b32.step  = s;
        b32.start = 1'b1;
        @(posedge clk);
        #1;
        b32.start = 1'b0;
        b32.mode  = 2'b01;
        b32.count = 8'hFF;
        b32.init  = 32'h5555_5555;
        b32.step  = 32'h0000_1234;
    endtask

    task automatic wait_done32(output int n);
        n = 0;
        while (b32.done !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run32(input string name, input logic [1:0] m, input logic [7:0] c,
                         input logic [31:0] i, input logic [31:0] s,
                         input logic [31:0] exp_out, input logic exp_ovf);
        int n;
        start32(m, c, i, s);
        check({name, ".busy_after_start"}, 64'(b32.busy), 64'd1);
        wait_done32(n);
        check({name, ".done_seen"},  64'(b32.done), 64'd1);
        check({name, ".latency"},    64'(n), 64'(c));
        check({name, ".out"},        64'(b32.out), 64'(exp_out));
        check({name, ".iter"},       64'(b32.iter), 64'(c));
        check({name, ".ovf"},        64'(b32.ovf), 64'(exp_ovf));
        @(posedge clk);
        #1;
        check({name, ".done_pulse"}, 64'(b32.done), 64'd0);
        check({name, ".busy_low"},   64'(b32.busy), 64'd0);
        check({name, ".out_hold"},   64'(b32.out), 64'(exp_out));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        b32.start = 1'b0; b32.mode = 2'b00; b32.count = 8'd0; b32.init = 32'd0; b32.step = 32'd0;
        b8.start  = 1'b0; b8.mode  = 2'b00; b8.count  = 8'd0; b8.init  = 8'd0;  b8.step  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst.out",  64'(b32.out),  64'd0);
        check("rst.iter", 64'(b32.iter), 64'd0);
        check("rst.busy", 64'(b32.busy), 64'd0);
        check("rst.done", 64'(b32.done), 64'd0);
        check("rst.ovf",  64'(b32.ovf),  64'd0);
        check("rst8.out", 64'(b8.out),   64'd0);

        run32("add31",  2'b00, 8'd31, 32'd0,   32'd1, 32'd31, 1'b0);
        run32("idx10",  2'b10, 8'd10, 32'd0,   32'd0, 32'd45, 1'b0);
        run32("sub5",   2'b01, 8'd5,  32'd100, 32'd7, 32'd65, 1'b0);
        run32("borrow", 2'b01, 8'd1,  32'd1,   32'd2, 32'hFFFF_FFFF, 1'b1);
        run32("rsvd",   2'b11, 8'd2,  32'd5,   32'd3, 32'd11, 1'b0);
        run32("cnt0",   2'b00, 8'd0,  32'hDEAD_BEEF, 32'd9, 32'hDEAD_BEEF, 1'b0);

        // 8-bit wrap: F0+10+10 carries out once and lands on 10.
        @(negedge clk);
        b8.mode = 2'b00; b8.count = 8'd2; b8.init = 8'hF0; b8.step = 8'h10; b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("w8.done", 64'(b8.done), 64'd1);
        check("w8.out",  64'(b8.out),  64'h10);
        check("w8.ovf",  64'(b8.ovf),  64'd1);
        @(posedge clk);
        @(negedge clk);
        b8.mode = 2'b00; b8.count = 8'd1; b8.init = 8'h00; b8.step = 8'h01; b8.start = 1'b1;
        @(posedge clk);
        #1;
        b8.start = 1'b0;
        check("w8b.ovf_cleared", 64'(b8.ovf), 64'd0);
        @(posedge clk);
        #1;
        check("w8b.done", 64'(b8.done), 64'd1);
        check("w8b.out",  64'(b8.out),  64'h01);
        check("w8b.ovf",  64'(b8.ovf),  64'd0);

        // start held high: the DONE cycle ignores it, the following IDLE cycle accepts it.
        @(negedge clk);
        b32.mode = 2'b00; b32.count = 8'd3; b32.init = 32'd0; b32.step = 32'd2; b32.start = 1'b1;
        @(posedge clk);
        #1;
        wait_done32(edges);
        check("hold.latency", 64'(edges), 64'd3);
        check("hold.out",     64'(b32.out), 64'd6);
        b32.count = 8'd1; b32.init = 32'd100; b32.step = 32'd5;
        @(posedge clk);
        #1;
        check("hold.idle_busy", 64'(b32.busy), 64'd0);
        check("hold.idle_done", 64'(b32.done), 64'd0);
        check("hold.idle_out",  64'(b32.out),  64'd6);
        @(posedge clk);
        #1;
        b32.start = 1'b0;
        check("hold.rerun_busy", 64'(b32.busy), 64'd1);
        check("hold.rerun_out",  64'(b32.out),  64'd100);
        check("hold.rerun_iter", 64'(b32.iter), 64'd0);
        @(posedge clk);
        #1;
        check("hold.rerun_done", 64'(b32.done), 64'd1);
        check("hold.rerun_res",  64'(b32.out),  64'd105);

        // Reset abandons a run at iteration 4.
        @(posedge clk);
        start32(2'b00, 8'd20, 32'd0, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("abort.iter_before", 64'(b32.iter), 64'd4);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort.out",  64'(b32.out),  64'd0);
        check("abort.iter", 64'(b32.iter), 64'd0);
        check("abort.busy", 64'(b32.busy), 64'd0);
        check("abort.done", 64'(b32.done), 64'd0);
        edges = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (b32.done === 1'b1 || b32.busy === 1'b1) edges++;
        end
        check("abort.no_activity", 64'(edges), 64'd0);
        run32("after_abort", 2'b00, 8'd2, 32'd0, 32'd3, 32'd6, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
